// File: rtl/hazard_scoreboard_if.sv
// Forwarding/hazard interface between the ID-stage control side and the hazard scoreboard.
// The master drives ID-stage requests; the slave returns stage tags and the stall.
interface hazard_scoreboard_if #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
);
   logic             forwarding_en;
   logic             freeze;
   logic             flush;
   logic             id_valid;
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_two_src;
   logic [REG_W-1:0] id_dest;
   logic             id_wb_en;
   logic             id_mem_r_en;
   logic             hazard;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic [REG_W-1:0] wb_dest;
   logic             wb_wb_en;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output forwarding_en, freeze, flush, id_valid, id_src1, id_src2, id_two_src,
             id_dest, id_wb_en, id_mem_r_en,
      input  hazard, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
             wb_dest, wb_wb_en, stall_count
   );

   modport slave (
      input  forwarding_en, freeze, flush, id_valid, id_src1, id_src2, id_two_src,
             id_dest, id_wb_en, id_mem_r_en,
      output hazard, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
             wb_dest, wb_wb_en, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes through EXE/MEM/WB, publishes their tags for
// forwarding, and raises the ID stall for RAW conflicts forwarding cannot cover.
module hazard_scoreboard #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  sb
);

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             mem_r_en;
   } slot_t;

   slot_t            r_exe;
   slot_t            r_mem;
   slot_t            r_wb;
   logic [CNT_W-1:0] r_stall_count;

   slot_t w_id_entry;
   logic  w_exe_match;
   logic  w_mem_match;
   logic  w_hazard;
   logic  w_accept;

   function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] src1,
                                       input logic [REG_W-1:0] src2, input logic two_src);
      return s.wb_en && ((s.dest == src1) || (two_src && (s.dest == src2)));
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_id_entry          = '0;
      w_id_entry.dest     = sb.id_dest;
      w_id_entry.wb_en    = sb.id_wb_en;
      w_id_entry.mem_r_en = sb.id_mem_r_en;

      w_exe_match = slot_match(r_exe, sb.id_src1, sb.id_src2, sb.id_two_src);
      w_mem_match = slot_match(r_mem, sb.id_src1, sb.id_src2, sb.id_two_src);

      // WB never stalls: the register file writes on the falling edge.
      w_hazard = 1'b0;
      if (sb.id_valid) begin
         if (sb.forwarding_en) w_hazard = w_exe_match && r_exe.mem_r_en;
         else                  w_hazard = w_exe_match || w_mem_match;
      end

      w_accept = sb.id_valid && !w_hazard && !sb.flush;
   end

   // NOTE: sequential state uses non-blocking assignments so every slot shifts on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exe         <= '0;
         r_mem         <= '0;
         r_wb          <= '0;
         r_stall_count <= '0;
      end else if (!sb.freeze) begin
         r_wb  <= r_mem;
         r_mem <= r_exe;
         r_exe <= w_accept ? w_id_entry : '0;
         if (w_hazard && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign sb.hazard       = w_hazard;
   assign sb.exe_dest     = r_exe.dest;
   assign sb.exe_wb_en    = r_exe.wb_en;
   assign sb.exe_mem_r_en = r_exe.mem_r_en;
   assign sb.mem_dest     = r_mem.dest;
   assign sb.mem_wb_en    = r_mem.wb_en;
   assign sb.wb_dest      = r_wb.dest;
   assign sb.wb_wb_en     = r_wb.wb_en;
   assign sb.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default-width instance for the pipeline
// scenarios and a CNT_W=4 instance for counter saturation.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) sb  ();
   hazard_scoreboard_if #(.REG_W(4), .CNT_W(4))  sb4 ();

   hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .sb(sb));
   hazard_scoreboard #(.REG_W(4), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .sb(sb4));

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one edge, then sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_id();
      sb.id_valid    = 1'b0;
      sb.id_src1     = '0;
      sb.id_src2     = '0;
      sb.id_two_src  = 1'b0;
      sb.id_dest     = '0;
      sb.id_wb_en    = 1'b0;
      sb.id_mem_r_en = 1'b0;
   endtask

   task automatic issue(input logic [3:0] dest, input logic wb, input logic ld,
                        input logic [3:0] s1, input logic [3:0] s2, input logic two);
      sb.id_valid    = 1'b1;
      sb.id_dest     = dest;
      sb.id_wb_en    = wb;
      sb.id_mem_r_en = ld;
      sb.id_src1     = s1;
      sb.id_src2     = s2;
      sb.id_two_src  = two;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_exe_dest"},  32'(sb.exe_dest),     32'h0);
      check({tag, "_exe_wb"},    32'(sb.exe_wb_en),    32'h0);
      check({tag, "_exe_ld"},    32'(sb.exe_mem_r_en), 32'h0);
      check({tag, "_mem_dest"},  32'(sb.mem_dest),     32'h0);
      check({tag, "_mem_wb"},    32'(sb.mem_wb_en),    32'h0);
      check({tag, "_wb_dest"},   32'(sb.wb_dest),      32'h0);
      check({tag, "_wb_wb"},     32'(sb.wb_wb_en),     32'h0);
      check({tag, "_stall"},     32'(sb.stall_count),  32'h0);
      check({tag, "_hazard"},    32'(sb.hazard),       32'h0);
   endtask

   initial begin
      rst              = 1'b1;
      sb.forwarding_en = 1'b1;
      sb.freeze        = 1'b0;
      sb.flush         = 1'b0;
      idle_id();
      sb4.forwarding_en = 1'b0;
      sb4.freeze        = 1'b0;
      sb4.flush         = 1'b0;
      sb4.id_valid      = 1'b0;
      sb4.id_src1       = '0;
      sb4.id_src2       = '0;
      sb4.id_two_src    = 1'b0;
      sb4.id_dest       = '0;
      sb4.id_wb_en      = 1'b0;
      sb4.id_mem_r_en   = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_empty("reset");
      check("reset_stall4", 32'(sb4.stall_count), 32'h0);

      // Load-use with forwarding: LDR r3 then ADD r4 <- r3.
      issue(4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
      check("lu_ldr_no_hazard", 32'(sb.hazard), 32'h0);
      step();
      check("lu_exe_dest", 32'(sb.exe_dest), 32'h3);
      check("lu_exe_ld",   32'(sb.exe_mem_r_en), 32'h1);
      issue(4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
      check("lu_hazard", 32'(sb.hazard), 32'h1);
      step();
      check("lu_bubble",   32'(sb.exe_wb_en), 32'h0);
      check("lu_mem_dest", 32'(sb.mem_dest), 32'h3);
      check("lu_mem_wb",   32'(sb.mem_wb_en), 32'h1);
      check("lu_stall",    32'(sb.stall_count), 32'h1);
      check("lu_hazard_clears", 32'(sb.hazard), 32'h0);
      step();
      check("lu_add_exe",  32'(sb.exe_dest), 32'h4);
      check("lu_add_wb",   32'(sb.exe_wb_en), 32'h1);
      check("lu_wb_dest",  32'(sb.wb_dest), 32'h3);
      check("lu_stall_hold", 32'(sb.stall_count), 32'h1);
      idle_id();

      // No forwarding, two-source RAW on src2.
      do_reset();
      sb.forwarding_en = 1'b0;
      issue(4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd6, 1'b1, 1'b0, 4'd1, 4'd5, 1'b1);
      check("nf_hazard_exe", 32'(sb.hazard), 32'h1);
      step();
      check("nf_mem_dest",   32'(sb.mem_dest), 32'h5);
      check("nf_hazard_mem", 32'(sb.hazard), 32'h1);
      step();
      check("nf_wb_dest",    32'(sb.wb_dest), 32'h5);
      check("nf_hazard_wb",  32'(sb.hazard), 32'h0);
      check("nf_stall",      32'(sb.stall_count), 32'h2);
      step();
      check("nf_sub_exe",    32'(sb.exe_dest), 32'h6);

      // Same with id_two_src=0: src2 is not read, so no hazard.
      do_reset();
      issue(4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd6, 1'b1, 1'b0, 4'd1, 4'd5, 1'b0);
      check("nf1_hazard", 32'(sb.hazard), 32'h0);
      step();
      check("nf1_exe",    32'(sb.exe_dest), 32'h6);
      check("nf1_stall",  32'(sb.stall_count), 32'h0);
      idle_id();

      // Freeze during a load-use stall.
      do_reset();
      sb.forwarding_en = 1'b1;
      issue(4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
      sb.freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("frz_exe_dest", 32'(sb.exe_dest), 32'h3);
         check("frz_exe_ld",   32'(sb.exe_mem_r_en), 32'h1);
         check("frz_mem_wb",   32'(sb.mem_wb_en), 32'h0);
         check("frz_stall",    32'(sb.stall_count), 32'h0);
         check("frz_hazard",   32'(sb.hazard), 32'h1);
      end
      sb.freeze = 1'b0;
      step();
      check("frz_resume_mem",   32'(sb.mem_dest), 32'h3);
      check("frz_resume_bub",   32'(sb.exe_wb_en), 32'h0);
      check("frz_resume_stall", 32'(sb.stall_count), 32'h1);
      idle_id();

      // Flush kills the entering instruction; older slots keep moving.
      do_reset();
      issue(4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      sb.flush = 1'b1;
      step();
      check("fl_exe_wb",   32'(sb.exe_wb_en), 32'h0);
      check("fl_mem_dest", 32'(sb.mem_dest), 32'h2);
      check("fl_mem_wb",   32'(sb.mem_wb_en), 32'h1);
      sb.flush = 1'b0;
      idle_id();
      step();
      check("fl_wb_dest",  32'(sb.wb_dest), 32'h2);
      check("fl_wb_wb",    32'(sb.wb_wb_en), 32'h1);
      check("fl_mem_bub",  32'(sb.mem_wb_en), 32'h0);

      // Flush together with hazard: bubble, counter still increments.
      issue(4'd3, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd4, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0);
      sb.flush = 1'b1;
      check("flh_hazard", 32'(sb.hazard), 32'h1);
      step();
      sb.flush = 1'b0;
      check("flh_bubble", 32'(sb.exe_wb_en), 32'h0);
      check("flh_stall",  32'(sb.stall_count), 32'h1);

      // Fill all slots, then reset mid-stream with freeze and flush asserted.
      issue(4'd9, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd10, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      issue(4'd11, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
      step();
      check("full_exe", 32'(sb.exe_dest), 32'hb);
      check("full_mem", 32'(sb.mem_dest), 32'ha);
      check("full_wb",  32'(sb.wb_dest),  32'h9);
      sb.freeze = 1'b1;
      sb.flush  = 1'b1;
      rst = 1'b1;
      step();
      rst       = 1'b0;
      sb.freeze = 1'b0;
      sb.flush  = 1'b0;
      idle_id();
      #1;
      check_empty("midrst");

      // Saturation on the 4-bit counter: a self-dependent LDR r3,[r3] without
      // forwarding stalls 2 of every 3 cycles.
      sb4.id_valid    = 1'b1;
      sb4.id_dest     = 4'd3;
      sb4.id_src1     = 4'd3;
      sb4.id_wb_en    = 1'b1;
      sb4.id_mem_r_en = 1'b1;
      for (int i = 0; i < 21; i++) step();
      check("sat_mid", 32'(sb4.stall_count), 32'he);
      for (int i = 0; i < 9; i++) step();
      check("sat_top", 32'(sb4.stall_count), 32'hf);
      for (int i = 0; i < 6; i++) step();
      check("sat_hold", 32'(sb4.stall_count), 32'hf);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks every in-flight register write from issue in ID through EXE, MEM and WB.
- Supplies the stage destination tags that the forwarding logic consumes: mem_dest/mem_wb_en and wb_dest/wb_wb_en.
- Raises the ID-stage stall (hazard) for RAW conflicts that forwarding cannot resolve: load-use when forwarding is on, any EXE/MEM RAW when it is off.
- Sits beside the ID/EXE/MEM/WB pipeline registers and is the producer side of the forwarding interface.

Parameters:
- REG_W, 4, register-address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- forwarding_en  in  1  forwarding enabled
- freeze  in  1  memory not ready; whole pipeline holds
- flush  in  1  branch taken; the instruction entering EXE is killed
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_W  first source register
- id_src2  in  REG_W  second source register
- id_two_src  in  1  id_src2 is actually read
- id_dest  in  REG_W  destination of the ID instruction
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_r_en  in  1  ID instruction is a load
- hazard  out  1  stall IF/ID; insert a bubble into EXE
- exe_dest  out  REG_W  EXE-stage destination tag
- exe_wb_en  out  1  EXE-stage write-back valid
- exe_mem_r_en  out  1  EXE-stage load flag
- mem_dest  out  REG_W  MEM-stage destination tag
- mem_wb_en  out  1  MEM-stage write-back valid
- wb_dest  out  REG_W  WB-stage destination tag
- wb_wb_en  out  1  WB-stage write-back valid
- stall_count  out  CNT_W  cycles with hazard=1 and freeze=0

Behaviour:
- Reset:
  - On a clk edge with rst=1, every tag, flag and stall_count goes to 0.
  - rst overrides freeze and flush; a reset in mid-stream discards all in-flight entries.
- Tag pipeline: three registered slots (EXE, MEM, WB), each holding {dest, wb_en, mem_r_en}.
- Advance: on each edge with freeze=0:
  - WB <= MEM.
  - MEM <= EXE.
  - EXE <= ID entry if id_valid=1, hazard=0 and flush=0; otherwise EXE <= bubble (all flags 0, dest 0).
- Freeze: with freeze=1, all slots and stall_count hold.
  - hazard is still computed and driven.
  - freeze has priority over flush; a flush seen during freeze has no effect, so the control unit must hold flush until freeze drops.
- Match definition (combinational): a slot matches if slot.wb_en=1 and (slot.dest==id_src1, or id_two_src=1 and slot.dest==id_src2).
- hazard (combinational from current slot state and ID inputs), forced to 0 when id_valid=0:
  - forwarding_en=1: hazard = EXE match AND exe_mem_r_en=1. This is load-use only; one bubble resolves it because the load then sits in MEM.
  - forwarding_en=0: hazard = EXE match OR MEM match.
  - The WB slot never causes a hazard, because the register file writes on the falling edge.
- Matches are on the tag value alone; register 15 gets no special treatment.
- Both sources matching count as one hazard.
- flush=1 with hazard=1: EXE gets a bubble either way; stall_count still increments.
- stall_count: increments by 1 on each edge with hazard=1 and freeze=0; saturates at all-ones, never wraps.
- Outputs: all tag outputs are the registered slot contents directly, with zero combinational path from ID inputs. hazard is the only combinational output.
- Latency: an entry accepted at edge N appears on exe_* after edge N, on mem_* after N+1 and on wb_* after N+2. Frozen cycles stretch this 1:1.

Test Plan:
- Reset and drain: pulse rst mid-stream with slots full → next cycle all tags, flags and stall_count are 0, hazard=0.
- Load-use with forwarding:
  - Stimulus: forwarding_en=1; issue LDR dest=3 (wb_en=1, mem_r_en=1), then ADD src1=3.
  - Required: hazard=1 for exactly 1 cycle, EXE gets a bubble, stall_count=1.
  - Next cycle: mem_dest=3, mem_wb_en=1, hazard=0, and the ADD enters EXE.
- No forwarding:
  - Stimulus: forwarding_en=0; issue ADD dest=5, then SUB src2=5 with id_two_src=1.
  - Required: hazard=1 for 2 cycles while dest 5 sits in EXE then MEM; hazard=0 once it reaches WB; stall_count=2.
  - Same sequence with id_two_src=0 → hazard=0 throughout.
- Freeze hold: freeze=1 for 4 cycles during a load-use stall → all tags and stall_count unchanged, hazard stays 1; advance resumes on the first cycle with freeze=0.
- Flush: flush=1 while id_valid=1 with dest=7 → exe_wb_en=0 on the next cycle; MEM and WB continue advancing normally.
- Saturation: CNT_W=4, hold a hazard unfrozen for 20 cycles → stall_count stops at 15.
